// File: rtl/wbs_spim.sv
// ---------------------------------------------------------------------------
// wbs_spim -- Wishbone B4 pipelined slave that tunnels each access as one
// SPI frame (mode 0) to a remote SPI-controlled Wishbone master.
//
// Frame layout (MSB first on every byte):
//   {we,3'b000,sel}, adr[7:0], [dat[31:24..7:0] if write],
//   0x00 poll bytes until the far side answers 0x01 (or POLL_MAX polls),
//   [four 0x00 bytes clocking in read data if read]
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wb_cyc_i .. wb_dat_i     Wishbone request side
//   wb_dat_o                 read data, updated together with ack/err
//   wb_stall_o               low only while idle
//   wb_ack_o / wb_err_o      one-cycle completion / timeout pulse
//   spi_sck/csn/sdo/sdi      SPI master pins (SCK idles low)
//
// Handshake: a request is taken on a cycle where wb_cyc_i && wb_stb_i &&
// !wb_stall_o; exactly one of ack/err pulses for one cycle when the frame
// ends, unless wb_cyc_i dropped in the meantime, in which case the frame
// still completes on SPI but no pulse is produced.
// ---------------------------------------------------------------------------
module wbs_spim #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned POLL_MAX = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        spi_sck,
    output logic        spi_csn,
    output logic        spi_sdo,
    input  logic        spi_sdi
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_HDR,
        S_ADR,
        S_WDATA,
        S_POLL,
        S_RDATA,
        S_DONE,
        S_GAP
    } state_e;

    localparam logic [8:0] PHASE_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [7:0] POLL_LAST  = 8'(POLL_MAX - 1);

    state_e      state_q,   state_d;
    logic [8:0]  cnt_q,     cnt_d;      // SCK phase / setup / gap timer
    logic [2:0]  bit_q,     bit_d;
    logic [1:0]  byte_q,    byte_d;
    logic [7:0]  poll_q,    poll_d;
    logic        sck_q,     sck_d;
    logic [7:0]  tx_q,      tx_d;       // bit 7 drives SDO
    logic [7:0]  rx_q,      rx_d;
    logic        we_q,      we_d;
    logic [7:0]  adr_q,     adr_d;
    logic [31:0] wdat_q,    wdat_d;     // write bytes still to send, MSB first
    logic [23:0] rdat_q,    rdat_d;     // first three read bytes
    logic [31:0] dat_o_q,   dat_o_d;
    logic        timeout_q, timeout_d;
    logic        abort_q,   abort_d;    // wb_cyc_i dropped during this access

    // the upper address byte is intentionally not forwarded
    logic unused_adr_hi;
    assign unused_adr_hi = ^wb_adr_i[15:8];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            poll_q    <= '0;
            sck_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            dat_o_q   <= '0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            poll_q    <= poll_d;
            sck_q     <= sck_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            dat_o_q   <= dat_o_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    logic in_byte;
    logic sample_sdi;
    logic byte_end;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        poll_d    = poll_q;
        sck_d     = sck_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        dat_o_d   = dat_o_q;
        timeout_d = timeout_q;
        abort_d   = abort_q;
        byte_end  = 1'b0;

        in_byte    = (state_q == S_HDR)   || (state_q == S_ADR)  ||
                     (state_q == S_WDATA) || (state_q == S_POLL) ||
                     (state_q == S_RDATA);
        sample_sdi = (state_q == S_POLL)  || (state_q == S_RDATA);

        // Bit engine: low phase then high phase, CLK_DIV cycles each.
        // SDI is captured as SCK rises; TX advances as SCK falls.
        if (in_byte) begin
            if (cnt_q == PHASE_LAST) begin
                cnt_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    if (sample_sdi) begin
                        rx_d = {rx_q[6:0], spi_sdi};
                    end
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        bit_d    = '0;
                        byte_end = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
            end else begin
                cnt_d = cnt_q + 9'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d      = wb_we_i;
                    adr_d     = wb_adr_i[7:0];
                    wdat_d    = wb_dat_i;
                    timeout_d = 1'b0;
                    abort_d   = 1'b0;
                    cnt_d     = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    poll_d    = '0;
                    sck_d     = 1'b0;
                    if (wb_sel_i == 4'h0) begin
                        // nothing to transfer: answer immediately
                        state_d = S_DONE;
                        dat_o_d = '0;
                    end else begin
                        state_d = S_SETUP;
                        tx_d    = {wb_we_i, 3'b000, wb_sel_i};
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HDR;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_HDR: begin
                if (byte_end) begin
                    state_d = S_ADR;
                    tx_d    = adr_q;
                end
            end
            S_ADR: begin
                if (byte_end) begin
                    if (we_q) begin
                        state_d = S_WDATA;
                        byte_d  = '0;
                        tx_d    = wdat_q[31:24];
                        wdat_d  = {wdat_q[23:0], 8'h00};
                    end else begin
                        state_d = S_POLL;
                        poll_d  = '0;
                        tx_d    = 8'h00;
                    end
                end
            end
            S_WDATA: begin
                if (byte_end) begin
                    if (byte_q == 2'd3) begin
                        state_d = S_POLL;
                        poll_d  = '0;
                        tx_d    = 8'h00;
                    end else begin
                        byte_d = byte_q + 2'd1;
                        tx_d   = wdat_q[31:24];
                        wdat_d = {wdat_q[23:0], 8'h00};
                    end
                end
            end
            S_POLL: begin
                if (byte_end) begin
                    poll_d = poll_q + 8'd1;
                    tx_d   = 8'h00;
                    if (rx_q == 8'h01) begin
                        if (we_q) begin
                            state_d = S_DONE;
                            dat_o_d = '0;
                        end else begin
                            state_d = S_RDATA;
                            byte_d  = '0;
                        end
                    end else if (poll_q == POLL_LAST) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        dat_o_d   = '0;
                    end
                end
            end
            S_RDATA: begin
                if (byte_end) begin
                    rdat_d = {rdat_q[15:0], rx_q};
                    tx_d   = 8'h00;
                    if (byte_q == 2'd3) begin
                        state_d = S_DONE;
                        dat_o_d = {rdat_q, rx_q};
                    end else begin
                        byte_d = byte_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // once the master abandons the cycle, the result is never reported
        if ((state_q != S_IDLE) && !wb_cyc_i) begin
            abort_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic frame_on;
    logic report;

    always_comb begin
        frame_on   = (state_q == S_SETUP) || (state_q == S_HDR)  ||
                     (state_q == S_ADR)   || (state_q == S_WDATA) ||
                     (state_q == S_POLL)  || (state_q == S_RDATA);
        report     = (state_q == S_DONE) && !abort_q && wb_cyc_i;

        wb_stall_o = (state_q != S_IDLE);
        wb_ack_o   = report && !timeout_q;
        wb_err_o   = report && timeout_q;
        wb_dat_o   = dat_o_q;
        spi_csn    = !frame_on;
        spi_sck    = sck_q;
        spi_sdo    = frame_on ? tx_q[7] : 1'b0;
    end

endmodule

// File: tb/tb_wbs_spim.sv
// ---------------------------------------------------------------------------
// tb_wbs_spim -- directed bench for wbs_spim with a behavioural SPI slave.
// MOSI bytes and Wishbone responses are checked against expected queues
// filled when each request is issued.
// ---------------------------------------------------------------------------
module tb_wbs_spim;

    localparam int CD      = 2;
    localparam int PM      = 4;
    localparam int LAT_EXP = 1 + CD + 7 * 16 * CD + 1;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [15:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_o;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_sdo;
    logic        spi_sdi;

    wbs_spim #(
        .CLK_DIV  (CD),
        .POLL_MAX (PM)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_we_i    (wb_we),
        .wb_sel_i   (wb_sel),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat_w),
        .wb_dat_o   (wb_dat_o),
        .wb_stall_o (wb_stall_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .spi_sck    (spi_sck),
        .spi_csn    (spi_csn),
        .spi_sdo    (spi_sdo),
        .spi_sdi    (spi_sdi)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // ---------------- scoreboard state ----------------
    logic [7:0]  exp_q[$];      // expected MOSI bytes
    logic [33:0] exp_rsp_q[$];  // expected {ack, err, dat}
    logic [7:0]  miso_q[$];     // bytes the slave model answers with

    int n_checks  = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int rsp_cnt   = 0;
    int ack_cnt   = 0;
    int err_cnt   = 0;
    int csn_falls = 0;
    int last_rsp_cyc = 0;
    int accept_cyc   = 0;
    int csn_rise_cyc = -1;
    int min_gap      = 1000;
    int gap;
    int bitn = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] miso_sh = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- Wishbone response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (wb_ack_o || wb_err_o)) begin
            rsp_cnt++;
            last_rsp_cyc = cyc_cnt;
            if (wb_ack_o) ack_cnt++;
            if (wb_err_o) err_cnt++;
            if (exp_rsp_q.size() == 0) check("rsp_unexpected", 64'(exp_rsp_q.size()), 64'd1);
            else check("rsp", {30'd0, wb_ack_o, wb_err_o, wb_dat_o}, {30'd0, exp_rsp_q.pop_front()});
        end
    end

    // ---------------- SPI slave model (mode 0) ----------------
    always @(negedge spi_csn) begin
        csn_falls++;
        bitn = 0;
        if (csn_rise_cyc >= 0) begin
            gap = cyc_cnt - csn_rise_cyc;
            if (gap < min_gap) min_gap = gap;
        end
        miso_sh = (miso_q.size() != 0) ? miso_q[0] : 8'h00;
        spi_sdi = miso_sh[7];
    end

    always @(posedge spi_csn) csn_rise_cyc = cyc_cnt;

    always @(posedge spi_sck) begin
        if (!spi_csn) begin
            if ((bitn % 8) == 0 && miso_q.size() != 0) void'(miso_q.pop_front());
            mosi_sh = {mosi_sh[6:0], spi_sdo};
            bitn++;
            if ((bitn % 8) == 0) begin
                if (exp_q.size() == 0) check("mosi_unexpected", 64'(exp_q.size()), 64'd1);
                else check("mosi_byte", 64'(mosi_sh), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_csn) begin
            if ((bitn % 8) == 0) miso_sh = (miso_q.size() != 0) ? miso_q[0] : 8'h00;
            else miso_sh = {miso_sh[6:0], 1'b0};
            spi_sdi = miso_sh[7];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_issue(input logic w, input logic [3:0] s, input logic [15:0] a,
                            input logic [31:0] d, output int stalled);
        int guard;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w; wb_sel = s; wb_adr = a; wb_dat_w = d;
        guard = 0;
        while (wb_stall_o && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (wb_stall_o) check("accept_timeout", 64'(wb_stall_o), 64'd0);
        stalled    = guard;
        accept_cyc = cyc_cnt;
        @(posedge clk);
        #1 wb_stb = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int guard = 0;
        while (rsp_cnt < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_cnt < target) check("rsp_timeout", 64'(rsp_cnt), 64'(target));
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((wb_stall_o || !spi_csn) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (wb_stall_o) check("idle_timeout", 64'(wb_stall_o), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_bytes(input logic [7:0] b[], input bit to_mosi);
        foreach (b[i]) begin
            if (to_mosi) exp_q.push_back(b[i]);
            else miso_q.push_back(b[i]);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        int falls0;
        int acks0;
        int errs0;
        int rsp0;
        int guard;

        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_sel = 4'h0; wb_adr = 16'h0; wb_dat_w = 32'h0; spi_sdi = 1'b0;

        #2;
        check("rst_csn",   64'(spi_csn),    64'd1);
        check("rst_sck",   64'(spi_sck),    64'd0);
        check("rst_sdo",   64'(spi_sdo),    64'd0);
        check("rst_stall", 64'(wb_stall_o), 64'd0);
        check("rst_ack",   64'({wb_ack_o, wb_err_o}), 64'd0);
        check("rst_dat",   64'(wb_dat_o),   64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        csn_falls = 0; csn_rise_cyc = -1; min_gap = 1000;

        // write 0x1234 <- DEADBEEF, two busy polls
        push_bytes('{8'h8F, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        exp_rsp_q.push_back({1'b1, 1'b0, 32'h0});
        falls0 = csn_falls; acks0 = ack_cnt;
        wb_issue(1'b1, 4'hF, 16'h1234, 32'hDEADBEEF, st);
        wait_rsp(rsp_cnt + 1);
        check("wr_latency", 64'(last_rsp_cyc - accept_cyc + 1), 64'(LAT_EXP + 2 * 16 * CD));
        wait_idle();
        check("wr_csn_windows", 64'(csn_falls - falls0), 64'd1);
        check("wr_mosi_done",   64'(exp_q.size()),       64'd0);
        check("wr_one_ack",     64'(ack_cnt - acks0),    64'd1);

        // read 0x0042, poll answered at once
        push_bytes('{8'h03, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);
        exp_rsp_q.push_back({1'b1, 1'b0, 32'h12345678});
        falls0 = csn_falls; acks0 = ack_cnt;
        wb_issue(1'b0, 4'h3, 16'h0042, $urandom, st);
        wait_rsp(rsp_cnt + 1);
        check("rd_latency", 64'(last_rsp_cyc - accept_cyc + 1), 64'(LAT_EXP));
        wait_idle();
        check("rd_csn_windows", 64'(csn_falls - falls0), 64'd1);
        check("rd_mosi_done",   64'(exp_q.size()),       64'd0);
        check("rd_one_ack",     64'(ack_cnt - acks0),    64'd1);

        // sel == 0 read: immediate answer, no SPI traffic
        exp_rsp_q.push_back({1'b1, 1'b0, 32'h0});
        falls0 = csn_falls;
        wb_issue(1'b0, 4'h0, 16'h0077, 32'h0, st);
        wait_rsp(rsp_cnt + 1);
        check("sel0_latency", 64'(last_rsp_cyc - accept_cyc + 1), 64'd2);
        wait_idle();
        check("sel0_no_csn", 64'(csn_falls - falls0), 64'd0);

        // timeout: slave never answers 0x01
        push_bytes('{8'h0F, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        exp_rsp_q.push_back({1'b0, 1'b1, 32'h0});
        falls0 = csn_falls; acks0 = ack_cnt; errs0 = err_cnt;
        wb_issue(1'b0, 4'hF, 16'h0055, 32'h0, st);
        wait_rsp(rsp_cnt + 1);
        wait_idle();
        check("to_err_pulse", 64'(err_cnt - errs0),   64'd1);
        check("to_no_ack",    64'(ack_cnt - acks0),   64'd0);
        check("to_polls",     64'(exp_q.size()),      64'd0);
        check("to_csn_high",  64'(spi_csn),           64'd1);

        // back-to-back: write then read, second waits for idle
        push_bytes('{8'h81, 8'h10, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        push_bytes('{8'h0C, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0);
        exp_rsp_q.push_back({1'b1, 1'b0, 32'h0});
        exp_rsp_q.push_back({1'b1, 1'b0, 32'hCAFEF00D});
        falls0 = csn_falls; rsp0 = rsp_cnt;
        csn_rise_cyc = -1; min_gap = 1000;
        wb_issue(1'b1, 4'h1, 16'hFF10, 32'hA5A50001, st);
        wb_issue(1'b0, 4'hC, 16'h0020, 32'h0, st);
        check("b2b_stalled", 64'(st != 0), 64'd1);
        wait_rsp(rsp0 + 2);
        wait_idle();
        check("b2b_two_frames", 64'(csn_falls - falls0), 64'd2);
        check("b2b_gap",        64'(min_gap >= 2 * CD),  64'd1);
        check("b2b_mosi_done",  64'(exp_q.size()),       64'd0);

        // cycle dropped mid-frame: frame completes, no pulse
        push_bytes('{8'h82, 8'h99, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        rsp0 = rsp_cnt;
        wb_issue(1'b1, 4'h2, 16'h0099, 32'h11223344, st);
        @(negedge clk);
        wb_cyc = 1'b0;
        wait_idle();
        check("drop_no_rsp",   64'(rsp_cnt - rsp0), 64'd0);
        check("drop_frame_ok", 64'(exp_q.size()),   64'd0);

        // reset during a write-data byte, then a normal write
        push_bytes('{8'h8F, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        acks0 = ack_cnt;
        wb_issue(1'b1, 4'hF, 16'h005A, 32'h01020304, st);
        guard = 0;
        while (exp_q.size() > 4 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reached_wdata", 64'(exp_q.size()), 64'd4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_csn",   64'(spi_csn),    64'd1);
        check("mid_rst_sck",   64'(spi_sck),    64'd0);
        check("mid_rst_sdo",   64'(spi_sdo),    64'd0);
        check("mid_rst_stall", 64'(wb_stall_o), 64'd0);
        exp_q.delete();
        miso_q.delete();
        repeat (2) @(negedge clk);
        check("mid_rst_no_ack", 64'(ack_cnt - acks0), 64'd0);

        push_bytes('{8'h85, 8'h3C, 8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'h00}, 1'b1);
        push_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        exp_rsp_q.push_back({1'b1, 1'b0, 32'h0});
        csn_rise_cyc = -1;
        rst_n = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'h5;
        wb_adr = 16'hAB3C; wb_dat_w = 32'h0BADF00D;
        accept_cyc = cyc_cnt;
        @(posedge clk);
        #1 wb_stb = 1'b0;
        check("post_rst_accepted", 64'(wb_stall_o), 64'd1);
        wait_rsp(rsp_cnt + 1);
        check("post_rst_latency", 64'(last_rsp_cyc - accept_cyc + 1), 64'(LAT_EXP));
        wait_idle();
        check("post_rst_ack",  64'(ack_cnt - acks0), 64'd1);
        check("post_rst_mosi", 64'(exp_q.size()),    64'd0);
        check("rsp_all_seen",  64'(exp_rsp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, n_checks);
        $finish;
    end

endmodule
